// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default
// latency and the widths used by the address check and latency counter.
package mem_if_pkg;

    localparam int DEFAULT_LATENCY = 2;
    localparam int CNT_W           = 4;   // holds LATENCY-1 for LATENCY up to 15
    localparam int ADDR_W          = 32;
    localparam int ALIGN_BITS      = 2;   // word alignment of byte addresses

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/byte_en_ram.sv
// Word-organised RAM with per-byte-lane write enables and a registered read.
// Each lane is its own array so every lane maps onto a plain inferred RAM.
module byte_en_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be,
    output logic [31:0]      rdata
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH_WORDS];
        logic [7:0] rdata_lane_q;

        always_ff @(posedge clk) begin
            if (wr_en && be[gi]) begin
                mem_lane[addr] <= wdata[gi*8 +: 8];
            end
            if (rd_en) begin
                rdata_lane_q <= mem_lane[addr];
            end
        end

        assign rdata[gi*8 +: 8] = rdata_lane_q;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Latency-programmable data-memory responder for a simple core: accepts one
// load/store, waits LATENCY edges, then holds the response until consumed.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              rsp_err_q;
    logic              rsp_load_q;
    logic [31:0]       ram_rdata;

    logic accept;
    logic access;
    logic addr_err;

    assign accept   = (state_q == ST_IDLE) && req_valid;
    assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
    assign addr_err = (addr_q[ALIGN_BITS-1:0] != '0) ||
                      (addr_q[ADDR_W-1:IDX_W+ALIGN_BITS] != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (access) begin
                rsp_err_q  <= addr_err;
                rsp_load_q <= !we_q && !addr_err;
            end
        end
    end

    // The RAM read register only updates on a load access, so gating it with
    // rsp_load_q yields a stable, reset-clean response word.
    assign rsp_rdata = rsp_load_q ? ram_rdata : 32'h0;
    assign rsp_err   = rsp_err_q;

    byte_en_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk  (clk),
        .wr_en(access && we_q && !addr_err),
        .rd_en(access && !we_q && !addr_err),
        .addr (addr_q[IDX_W+ALIGN_BITS-1:ALIGN_BITS]),
        .wdata(wdata_q),
        .be   (be_q),
        .rdata(ram_rdata)
    );

endmodule
